// File: rtl/axppa_error_monitor.sv
// axppa_error_monitor: windowed error statistics (count, sum, max of |exact - approx|)
// for an approximate adder under test. Define AXPPA_MON_BIAS_EN to enable the signed bias sum.
module axppa_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH:0]   in_sum,
  output logic             busy,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] bias_sum
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  typedef struct packed {
    logic           vld;
    logic [WIDTH:0] exact;
    logic [WIDTH:0] approx;
  } smp_t;

  state_t           state, state_nxt;
  smp_t             s1;
  logic [CNT_W-1:0] win_q, acc_cnt;
  logic             accept, clear;
  logic [WIDTH:0]   exact;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   ed;
  logic [ACC_W:0]   sum_ext;

  assign exact     = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
  assign accept    = in_valid && in_ready;
  assign clear     = (state == IDLE) && start;
  assign in_ready  = (state == ACCUM) && (acc_cnt < win_q);
  assign busy      = (state != IDLE);
  assign rep_valid = (state == REPORT);

  // Stage-2 arithmetic: two's-complement E - approx and its magnitude.
  assign diff    = {1'b0, s1.exact} - {1'b0, s1.approx};
  assign ed      = diff[WIDTH+1] ? (~diff[WIDTH:0] + (WIDTH+1)'(1)) : diff[WIDTH:0];
  assign sum_ext = {1'b0, sum_ed} + {{(ACC_W-WIDTH){1'b0}}, ed};

  // A zero-length window still passes through DRAIN so report latency matches
  // the normal two-cycle path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (win_len == '0) ? DRAIN : ACCUM;
      ACCUM:   if (accept && (acc_cnt + CNT_W'(1) == win_q)) state_nxt = DRAIN;
      DRAIN:   state_nxt = REPORT;
      REPORT:  if (rep_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s1      <= '0;
      win_q   <= '0;
      acc_cnt <= '0;
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else begin
      state  <= state_nxt;
      s1.vld <= accept;
      if (accept) begin
        s1.exact  <= exact;
        s1.approx <= in_sum;
      end
      if (clear) begin
        win_q   <= win_len;
        acc_cnt <= '0;
        err_cnt <= '0;
        sum_ed  <= '0;
        max_ed  <= '0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
        if (s1.vld) begin
          if (ed != '0) err_cnt <= err_cnt + CNT_W'(1);
          sum_ed <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
          if (ed > max_ed) max_ed <= ed;
        end
      end
    end
  end

`ifdef AXPPA_MON_BIAS_EN
  logic [ACC_W-1:0] bias_q;
  logic [ACC_W:0]   bias_nxt;

  assign bias_nxt = {bias_q[ACC_W-1], bias_q} + {{(ACC_W-WIDTH-1){diff[WIDTH+1]}}, diff};

  // Overflow shows as disagreement between the guard bit and the sign bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bias_q <= '0;
    end else if (s1.vld) begin
      if (bias_nxt[ACC_W] != bias_nxt[ACC_W-1])
        bias_q <= bias_nxt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        bias_q <= bias_nxt[ACC_W-1:0];
    end
  end

  assign bias_sum = bias_q;
`else
  assign bias_sum = '0;
`endif

endmodule

// File: tb/tb_axppa_error_monitor.sv
// Self-checking bench for axppa_error_monitor: vector table, hand sequences for
// latency/reset/saturation corners, and randomized windows against a statistics model.
module tb_axppa_error_monitor;
  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;
  localparam longint SUM_MAX  = 64'd4294967295;
  localparam longint BIAS_MAX = 64'd2147483647;
  localparam longint BIAS_MIN = -64'd2147483648;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_cin, rep_ready;
  logic [CNT_W-1:0] win_len;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH:0]   in_sum, max_ed;
  logic             in_ready, busy, rep_valid;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] sum_ed, bias_sum;

  int     checks = 0, failures = 0;
  int     cyc = 0;
  longint m_err, m_sum, m_max, m_bias;

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH:0]   s;
    longint           e_err, e_sum, e_max, e_bias;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axppa_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sum(in_sum), .busy(busy), .rep_valid(rep_valid),
    .rep_ready(rep_ready), .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed),
    .bias_sum(bias_sum)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint exp_bias(input longint b);
`ifdef AXPPA_MON_BIAS_EN
    return b;
`else
    return 0;
`endif
  endfunction

  // Reference statistics straight from the definitions, on plain integers.
  task automatic model_clear();
    m_err = 0; m_sum = 0; m_max = 0; m_bias = 0;
  endtask

  task automatic model_add(input longint a, input longint b, input longint c, input longint s);
    longint e, d, ed;
    e  = a + b + c;
    d  = e - s;
    ed = (d < 0) ? -d : d;
    if (ed != 0) m_err++;
    m_sum  = (m_sum + ed > SUM_MAX) ? SUM_MAX : m_sum + ed;
    m_max  = (ed > m_max) ? ed : m_max;
    m_bias = m_bias + d;
    if (m_bias > BIAS_MAX) m_bias = BIAS_MAX;
    if (m_bias < BIAS_MIN) m_bias = BIAS_MIN;
  endtask

  task automatic check_stats(input string nm);
    chk({nm, "_rep_valid"}, rep_valid, 1);
    chk({nm, "_err_cnt"}, err_cnt, m_err);
    chk({nm, "_sum_ed"}, sum_ed, m_sum);
    chk({nm, "_max_ed"}, max_ed, m_max);
    chk({nm, "_bias"}, longint'($signed(bias_sum)), exp_bias(m_bias));
  endtask

  task automatic do_start(input int len);
    int n = 0;
    while (busy && n < 100) begin cycle(); n++; end
    if (busy) chk("idle_timeout", busy, 0);
    model_clear();
    start = 1'b1;
    win_len = CNT_W'(len);
    cycle();
    start = 1'b0;
    win_len = CNT_W'($urandom);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, (len != 0) ? 1 : 0);
  endtask

  // Offer one sample and hold it until accepted; garbage is driven afterwards.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input logic [WIDTH:0] s);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; in_sum = s;
    while (!in_ready && n < 100) begin cycle(); n++; end
    if (!in_ready) begin
      chk("ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    cycle();
    in_valid = 1'b0;
    model_add(a, b, c, s);
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    in_cin = 1'($urandom); in_sum = (WIDTH+1)'($urandom);
  endtask

  task automatic release_report();
    in_valid = 1'b0;
    start = 1'b0;
    rep_ready = 1'b1;
    cycle();
    rep_ready = 1'b0;
    chk("rel_rep_valid", rep_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_sum_hold", sum_ed, m_sum);
  endtask

  // Called one cycle after the last accept (DRAIN); ignored starts/samples are offered.
  task automatic finish_report(input string nm, input int hold);
    chk({nm, "_drain_ready"}, in_ready, 0);
    chk({nm, "_drain_rep"}, rep_valid, 0);
    in_valid = 1'b1;
    cycle();
    check_stats(nm);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      win_len = 16'd7;
      cycle();
      chk({nm, "_hold_ready"}, in_ready, 0);
      check_stats({nm, "_hold"});
    end
    release_report();
  endtask

  task automatic rand_sample(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b,
                             output logic c, output logic [WIDTH:0] s);
    int e;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
    e = int'(a) + int'(b) + int'(c);
    case ($urandom_range(0, 2))
      0:       s = (WIDTH+1)'(e);
      1:       s = (WIDTH+1)'(e + int'($urandom_range(0, 16)) - 8);
      default: s = (WIDTH+1)'($urandom);
    endcase
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    logic             c;
    logic [WIDTH:0]   s;
    int               c0;

    tbl[0] = '{16'h1234, 16'h0001, 1'b0, 17'h01235, 0, 0, 0, 0};
    tbl[1] = '{16'h0000, 16'h0000, 1'b1, 17'h00003, 1, 2, 2, -2};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h00000, 1, 131071, 131071, 131071};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 17'h1FFFF, 1, 131071, 131071, -131071};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10001, 1, 1, 1, -1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; rep_ready = 1'b0; win_len = '0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sum = '0;
    model_clear();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rep_valid", rep_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sum_ed", sum_ed, 0);
    chk("rst_max_ed", max_ed, 0);
    chk("rst_bias", bias_sum, 0);

    // Single-sample windows from the vector table.
    for (int i = 0; i < 5; i++) begin
      do_start(1);
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s);
      chk("tbl_drain_rep", rep_valid, 0);
      cycle();
      chk("tbl_rep_valid", rep_valid, 1);
      chk("tbl_err_cnt", err_cnt, tbl[i].e_err);
      chk("tbl_sum_ed", sum_ed, tbl[i].e_sum);
      chk("tbl_max_ed", max_ed, tbl[i].e_max);
      chk("tbl_bias", longint'($signed(bias_sum)), exp_bias(tbl[i].e_bias));
      release_report();
    end

    // Exact samples, back to back.
    do_start(3);
    repeat (3) send(16'h1234, 16'h0001, 1'b0, 17'h01235);
    finish_report("exact", 1);

    // Approximation error with two-cycle statistics latency.
    do_start(2);
    send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
    chk("lat_t1_sum", sum_ed, 0);
    in_valid = 1'b1; in_a = 16'h0080; in_b = 16'h0080; in_cin = 1'b0; in_sum = 17'h00000;
    cycle();
    in_valid = 1'b0;
    model_add(16'h0080, 16'h0080, 0, 0);
    chk("lat_t2_sum", sum_ed, 4);
    finish_report("approx", 0);
    chk("approx_sum_ed", sum_ed, 260);
    chk("approx_max_ed", max_ed, 256);

    // Zero-length window.
    do_start(0);
    finish_report("zero", 2);

    // Reset after 2 of 4 samples, with the second still in stage 1.
    do_start(4);
    send(16'h0010, 16'h0010, 1'b0, 17'h00000);
    send(16'h0100, 16'h0000, 1'b0, 17'h00000);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_rep", rep_valid, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_sum", sum_ed, 0);
    chk("mid_rst_max", max_ed, 0);
    chk("mid_rst_bias", bias_sum, 0);
    cycle();
    chk("post_rst_sum", sum_ed, 0);
    chk("post_rst_rep", rep_valid, 0);
    do_start(1);
    send(16'h0000, 16'h0000, 1'b1, 17'h00003);
    finish_report("after_rst", 0);

    // Randomized windows with input gaps and held-off report consumer.
    for (int w = 0; w < 8; w++) begin
      int len;
      len = $urandom_range(1, 12);
      do_start(len);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 3)) cycle();
        rand_sample(a, b, c, s);
        send(a, b, c, s);
      end
      finish_report("rand", (w == 0) ? 5 : $urandom_range(0, 5));
    end

    // Saturation of sum_ed and bias, also checking one-sample-per-cycle throughput.
    do_start(32770);
    c0 = cyc;
    for (int i = 0; i < 32770; i++) send(16'hFFFF, 16'hFFFF, 1'b1, 17'h00000);
    chk("sat_throughput", cyc - c0, 32770);
    finish_report("sat", 0);
    chk("sat_sum_ed", sum_ed, SUM_MAX);
    chk("sat_err_cnt", err_cnt, 32770);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
